// File: rtl/cache_axi_interface.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_interface
// Description : Arbitrates ICache/DCache whole-line refills and DCache
//               write-backs, and serialises each 256-bit line into eight
//               32-bit beats on a word-level bus toward the AXI master.
//               The read and write paths are independent and may overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_interface (
  input  logic         clk,
  input  logic         rst,
  // ICache refill
  input  logic         inst_ren_i,
  input  logic [31:0]  inst_araddr_i,
  output logic         inst_rvalid_o,
  output logic [255:0] inst_rdata_o,
  // DCache refill
  input  logic         data_ren_i,
  input  logic [31:0]  data_araddr_i,
  output logic         data_rvalid_o,
  output logic [255:0] data_rdata_o,
  // DCache write-back
  input  logic         data_wen_i,
  input  logic [255:0] data_wdata_i,
  input  logic [31:0]  data_awaddr_i,
  output logic         data_bvalid_o,
  // Word-level bus toward the AXI master
  output logic         axi_ce_o,
  output logic [3:0]   axi_sel_o,
  input  logic [31:0]  rdata_i,
  input  logic         rdata_valid_i,
  output logic         axi_ren_o,
  output logic         axi_rready_o,
  output logic [31:0]  axi_raddr_o,
  input  logic         wdata_resp_i,
  output logic         axi_wen_o,
  output logic [31:0]  axi_waddr_o,
  output logic [31:0]  axi_wdata_o,
  output logic         axi_wvalid_o,
  output logic         axi_wlast_o
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_INST = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BUSY = 2'd1,
    W_DONE = 2'd2
  } wstate_t;

  rstate_t        r_rstate;
  logic [26:0]    r_rline;
  logic [2:0]     r_rcnt;
  logic [255:0]   r_rbuf;
  logic           r_ren;
  logic           r_inst_rvalid;
  logic           r_data_rvalid;
  logic [255:0]   r_inst_rdata;
  logic [255:0]   r_data_rdata;

  wstate_t        r_wstate;
  logic [26:0]    r_wline;
  logic [2:0]     r_wcnt;
  logic [255:0]   r_wbuf;
  logic           r_wen;
  logic           r_bvalid;

  logic [255:0]   w_rbuf_next;
  logic [31:0]    w_wword;

  // In-line offset bits of the request addresses carry no information here.
  logic w_unused;
  assign w_unused = &{1'b0, inst_araddr_i[4:0], data_araddr_i[4:0], data_awaddr_i[4:0]};

  // Read buffer with the incoming beat merged in; the completed line is
  // taken from here so the last word is visible in the same cycle as rvalid.
  always_comb begin
    w_rbuf_next = r_rbuf;
    w_rbuf_next[{r_rcnt, 5'b00000} +: 32] = rdata_i;
  end

  assign w_wword = r_wbuf[{r_wcnt, 5'b00000} +: 32];

  // Read FSM: DCache has priority at arbitration, an active transfer is never pre-empted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate      <= R_IDLE;
      r_rline       <= 27'd0;
      r_rcnt        <= 3'd0;
      r_rbuf        <= 256'd0;
      r_ren         <= 1'b0;
      r_inst_rvalid <= 1'b0;
      r_data_rvalid <= 1'b0;
      r_inst_rdata  <= 256'd0;
      r_data_rdata  <= 256'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (data_ren_i) begin
            r_rline  <= data_araddr_i[31:5];
            r_ren    <= 1'b1;
            r_rstate <= R_DATA;
          end else if (inst_ren_i) begin
            r_rline  <= inst_araddr_i[31:5];
            r_ren    <= 1'b1;
            r_rstate <= R_INST;
          end
        end
        R_INST, R_DATA: begin
          if (rdata_valid_i) begin
            r_rbuf <= w_rbuf_next;
            r_rcnt <= r_rcnt + 3'd1;
            if (r_rcnt == 3'd7) begin
              r_ren    <= 1'b0;
              r_rstate <= R_DONE;
              if (r_rstate == R_DATA) begin
                r_data_rdata  <= w_rbuf_next;
                r_data_rvalid <= 1'b1;
              end else begin
                r_inst_rdata  <= w_rbuf_next;
                r_inst_rvalid <= 1'b1;
              end
            end
          end
        end
        R_DONE: begin
          r_inst_rvalid <= 1'b0;
          r_data_rvalid <= 1'b0;
          r_rcnt        <= 3'd0;
          r_rstate      <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: latch the whole line, then stream one word per accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_wline  <= 27'd0;
      r_wcnt   <= 3'd0;
      r_wbuf   <= 256'd0;
      r_wen    <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (data_wen_i) begin
            r_wline  <= data_awaddr_i[31:5];
            r_wbuf   <= data_wdata_i;
            r_wen    <= 1'b1;
            r_wstate <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (wdata_resp_i) begin
            r_wcnt <= r_wcnt + 3'd1;
            if (r_wcnt == 3'd7) begin
              r_wen    <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_DONE;
            end
          end
        end
        W_DONE: begin
          r_bvalid <= 1'b0;
          r_wcnt   <= 3'd0;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign inst_rvalid_o = r_inst_rvalid;
  assign inst_rdata_o  = r_inst_rdata;
  assign data_rvalid_o = r_data_rvalid;
  assign data_rdata_o  = r_data_rdata;
  assign data_bvalid_o = r_bvalid;

  assign axi_sel_o     = 4'b1111;
  assign axi_ce_o      = r_ren | r_wen;
  assign axi_ren_o     = r_ren;
  assign axi_rready_o  = r_ren;
  assign axi_raddr_o   = r_ren ? {r_rline, r_rcnt, 2'b00} : 32'd0;
  assign axi_wen_o     = r_wen;
  assign axi_wvalid_o  = r_wen;
  assign axi_waddr_o   = r_wen ? {r_wline, r_wcnt, 2'b00} : 32'd0;
  assign axi_wdata_o   = r_wen ? w_wword : 32'd0;
  assign axi_wlast_o   = r_wen & (r_wcnt == 3'd7);

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_interface
// Description : Directed self-checking bench for cache_axi_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_interface;

  logic         clk = 1'b0;
  logic         rst;
  logic         inst_ren_i;
  logic [31:0]  inst_araddr_i;
  logic         inst_rvalid_o;
  logic [255:0] inst_rdata_o;
  logic         data_ren_i;
  logic [31:0]  data_araddr_i;
  logic         data_rvalid_o;
  logic [255:0] data_rdata_o;
  logic         data_wen_i;
  logic [255:0] data_wdata_i;
  logic [31:0]  data_awaddr_i;
  logic         data_bvalid_o;
  logic         axi_ce_o;
  logic [3:0]   axi_sel_o;
  logic [31:0]  rdata_i;
  logic         rdata_valid_i;
  logic         axi_ren_o;
  logic         axi_rready_o;
  logic [31:0]  axi_raddr_o;
  logic         wdata_resp_i;
  logic         axi_wen_o;
  logic [31:0]  axi_waddr_o;
  logic [31:0]  axi_wdata_o;
  logic         axi_wvalid_o;
  logic         axi_wlast_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] LINE_0 = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
  localparam logic [255:0] LINE_8 = 256'h80000007_80000006_80000005_80000004_80000003_80000002_80000001_80000000;
  localparam logic [255:0] LINE_9 = 256'h90000007_90000006_90000005_90000004_90000003_90000002_90000001_90000000;
  localparam logic [255:0] LINE_A = 256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;
  localparam logic [255:0] LINE_B = 256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000;
  localparam logic [255:0] LINE_C = 256'hC0000007_C0000006_C0000005_C0000004_C0000003_C0000002_C0000001_C0000000;
  localparam logic [255:0] LINE_D = 256'hD0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000;
  localparam logic [255:0] LINE_E = 256'hE0000007_E0000006_E0000005_E0000004_E0000003_E0000002_E0000001_E0000000;

  always #5 clk = ~clk;

  cache_axi_interface dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_araddr_i(inst_araddr_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_ren_i(data_ren_i), .data_araddr_i(data_araddr_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i),
    .data_awaddr_i(data_awaddr_i), .data_bvalid_o(data_bvalid_o),
    .axi_ce_o(axi_ce_o), .axi_sel_o(axi_sel_o),
    .rdata_i(rdata_i), .rdata_valid_i(rdata_valid_i),
    .axi_ren_o(axi_ren_o), .axi_rready_o(axi_rready_o), .axi_raddr_o(axi_raddr_o),
    .wdata_resp_i(wdata_resp_i), .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o),
    .axi_wdata_o(axi_wdata_o), .axi_wvalid_o(axi_wvalid_o), .axi_wlast_o(axi_wlast_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    rst = 1'b0;
    inst_ren_i = 0; inst_araddr_i = 0; data_ren_i = 0; data_araddr_i = 0;
    data_wen_i = 0; data_wdata_i = 0; data_awaddr_i = 0;
    rdata_i = 0; rdata_valid_i = 0; wdata_resp_i = 0;
    #12;
    ctl = {inst_rvalid_o, data_rvalid_o, data_bvalid_o, axi_ce_o, axi_ren_o,
           axi_rready_o, axi_wen_o, axi_wvalid_o, axi_wlast_o};
    n_checks++;
    if (ctl !== 9'd0) begin n_errors++; $display("FAIL reset_ctl: got %b want 0", ctl); end
    n_checks++;
    if (axi_sel_o !== 4'b1111) begin n_errors++; $display("FAIL reset_sel: got %h want f", axi_sel_o); end
    n_checks++;
    if ({axi_raddr_o, axi_waddr_o, axi_wdata_o} !== 96'd0) begin
      n_errors++; $display("FAIL reset_bus: raddr %h waddr %h wdata %h want 0", axi_raddr_o, axi_waddr_o, axi_wdata_o);
    end
    n_checks++;
    if ({inst_rdata_o, data_rdata_o} !== 512'd0) begin n_errors++; $display("FAIL reset_lines: got nonzero want 0"); end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (axi_ce_o !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: ce %b want 0", axi_ce_o); end
  endtask

  task automatic test_icache_read();
    logic [31:0] ea;
    inst_araddr_i = 32'h006C46A8; inst_ren_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h006C46A0 + i * 4;
      n_checks++;
      if ({axi_ren_o, axi_rready_o, axi_ce_o, inst_rvalid_o} !== 4'b1110) begin
        n_errors++; $display("FAIL icache_ctl beat %0d: ren/rdy/ce/rvalid %b%b%b%b want 1110", i, axi_ren_o, axi_rready_o, axi_ce_o, inst_rvalid_o);
      end
      n_checks++;
      if (axi_raddr_o !== ea) begin n_errors++; $display("FAIL icache_addr beat %0d: got %h want %h", i, axi_raddr_o, ea); end
      rdata_valid_i = 1'b1; rdata_i = i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if ({inst_rvalid_o, data_rvalid_o, axi_ren_o} !== 3'b100) begin
      n_errors++; $display("FAIL icache_done: irv/drv/ren %b%b%b want 100", inst_rvalid_o, data_rvalid_o, axi_ren_o);
    end
    n_checks++;
    if (inst_rdata_o !== LINE_0) begin n_errors++; $display("FAIL icache_line: got %h want %h", inst_rdata_o, LINE_0); end
    inst_ren_i = 1'b0;
    step();
    n_checks++;
    if (inst_rvalid_o !== 1'b0 || inst_rdata_o !== LINE_0) begin
      n_errors++; $display("FAIL icache_pulse_hold: rvalid %b line %h", inst_rvalid_o, inst_rdata_o);
    end
  endtask

  task automatic test_dcache_read();
    logic [31:0] ea;
    data_araddr_i = 32'h006C46A8; data_ren_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h006C46A0 + i * 4;
      n_checks++;
      if (axi_ren_o !== 1'b1 || axi_raddr_o !== ea) begin
        n_errors++; $display("FAIL dcache_addr beat %0d: ren %b addr %h want 1 %h", i, axi_ren_o, axi_raddr_o, ea);
      end
      rdata_valid_i = 1'b1; rdata_i = 32'h80000000 | i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if ({data_rvalid_o, inst_rvalid_o} !== 2'b10 || data_rdata_o !== LINE_8) begin
      n_errors++; $display("FAIL dcache_done: drv %b irv %b line %h want 1 0 %h", data_rvalid_o, inst_rvalid_o, data_rdata_o, LINE_8);
    end
    n_checks++;
    if (inst_rdata_o !== LINE_0) begin n_errors++; $display("FAIL dcache_inst_hold: got %h want %h", inst_rdata_o, LINE_0); end
    data_ren_i = 1'b0;
    step();
    n_checks++;
    if (data_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL dcache_pulse: got %b want 0", data_rvalid_o); end
  endtask

  task automatic test_dcache_write();
    logic [31:0] ea;
    logic [31:0] ed;
    data_awaddr_i = 32'h006C46A8; data_wdata_i = LINE_8; data_wen_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h006C46A0 + i * 4;
      ed = 32'h80000000 | i;
      if (i == 3) begin
        wdata_resp_i = 1'b0;
        step();
      end
      n_checks++;
      if ({axi_wen_o, axi_wvalid_o, axi_ce_o, data_bvalid_o} !== 4'b1110) begin
        n_errors++; $display("FAIL write_ctl beat %0d: wen/wv/ce/bv %b%b%b%b want 1110", i, axi_wen_o, axi_wvalid_o, axi_ce_o, data_bvalid_o);
      end
      n_checks++;
      if (axi_waddr_o !== ea || axi_wdata_o !== ed) begin
        n_errors++; $display("FAIL write_beat %0d: addr %h data %h want %h %h", i, axi_waddr_o, axi_wdata_o, ea, ed);
      end
      n_checks++;
      if (axi_wlast_o !== (i == 7)) begin n_errors++; $display("FAIL write_wlast beat %0d: got %b want %b", i, axi_wlast_o, (i == 7)); end
      wdata_resp_i = 1'b1;
      step();
    end
    wdata_resp_i = 1'b0;
    n_checks++;
    if (data_bvalid_o !== 1'b1 || axi_wen_o !== 1'b0) begin
      n_errors++; $display("FAIL write_done: bvalid %b wen %b want 1 0", data_bvalid_o, axi_wen_o);
    end
    data_wen_i = 1'b0;
    step();
    n_checks++;
    if (data_bvalid_o !== 1'b0 || axi_wen_o !== 1'b0) begin
      n_errors++; $display("FAIL write_pulse: bvalid %b wen %b want 0 0", data_bvalid_o, axi_wen_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] ea;
    inst_araddr_i = 32'hF06C46A8; data_araddr_i = 32'h006C46A8;
    inst_ren_i = 1'b1; data_ren_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h006C46A0 + i * 4;
      n_checks++;
      if (axi_raddr_o !== ea) begin n_errors++; $display("FAIL simul_data_addr beat %0d: got %h want %h", i, axi_raddr_o, ea); end
      rdata_valid_i = 1'b1; rdata_i = 32'h90000000 | i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if ({data_rvalid_o, inst_rvalid_o} !== 2'b10 || data_rdata_o !== LINE_9 || inst_rdata_o !== LINE_0) begin
      n_errors++; $display("FAIL simul_data_done: drv %b irv %b dline %h iline %h", data_rvalid_o, inst_rvalid_o, data_rdata_o, inst_rdata_o);
    end
    data_ren_i = 1'b0;
    step();
    n_checks++;
    if (axi_ren_o !== 1'b0) begin n_errors++; $display("FAIL simul_gap: ren %b want 0", axi_ren_o); end
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'hF06C46A0 + i * 4;
      n_checks++;
      if (axi_ren_o !== 1'b1 || axi_raddr_o !== ea) begin
        n_errors++; $display("FAIL simul_inst_addr beat %0d: ren %b addr %h want 1 %h", i, axi_ren_o, axi_raddr_o, ea);
      end
      rdata_valid_i = 1'b1; rdata_i = 32'hA0000000 | i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if ({inst_rvalid_o, data_rvalid_o} !== 2'b10 || inst_rdata_o !== LINE_A || data_rdata_o !== LINE_9) begin
      n_errors++; $display("FAIL simul_inst_done: irv %b drv %b iline %h dline %h", inst_rvalid_o, data_rvalid_o, inst_rdata_o, data_rdata_o);
    end
    inst_ren_i = 1'b0;
    step();
  endtask

  task automatic test_non_preemption();
    logic [31:0] ea;
    inst_araddr_i = 32'h12345678; inst_ren_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h12345660 + i * 4;
      if (i == 4) begin data_araddr_i = 32'h00001004; data_ren_i = 1'b1; end
      n_checks++;
      if (axi_raddr_o !== ea) begin n_errors++; $display("FAIL preempt_inst_addr beat %0d: got %h want %h", i, axi_raddr_o, ea); end
      rdata_valid_i = 1'b1; rdata_i = 32'hB0000000 | i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if ({inst_rvalid_o, data_rvalid_o} !== 2'b10 || inst_rdata_o !== LINE_B) begin
      n_errors++; $display("FAIL preempt_inst_done: irv %b drv %b line %h want 1 0 %h", inst_rvalid_o, data_rvalid_o, inst_rdata_o, LINE_B);
    end
    inst_ren_i = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      ea = 32'h00001000 + i * 4;
      rdata_valid_i = 1'b0;
      step();
      n_checks++;
      if (axi_ren_o !== 1'b1 || axi_raddr_o !== ea) begin
        n_errors++; $display("FAIL preempt_data_addr beat %0d: ren %b addr %h want 1 %h", i, axi_ren_o, axi_raddr_o, ea);
      end
      rdata_valid_i = 1'b1; rdata_i = 32'hC0000000 | i;
      step();
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== LINE_C || inst_rdata_o !== LINE_B) begin
      n_errors++; $display("FAIL preempt_data_done: drv %b dline %h iline %h", data_rvalid_o, data_rdata_o, inst_rdata_o);
    end
    data_ren_i = 1'b0;
    step();
  endtask

  task automatic test_concurrent();
    int rc, wc, k;
    bit rdone, wdone, rv, wv;
    data_araddr_i = 32'h00002000; data_ren_i = 1'b1;
    data_awaddr_i = 32'h00003010; data_wdata_i = LINE_E; data_wen_i = 1'b1;
    step();
    rc = 0; wc = 0; k = 0; rdone = 0; wdone = 0;
    while (!(rdone && wdone) && k < 80) begin
      rv = 0; wv = 0;
      if (!rdone) begin
        if (rc == 8) begin
          n_checks++;
          if (data_rvalid_o !== 1'b1 || data_rdata_o !== LINE_D) begin
            n_errors++; $display("FAIL conc_read_done: drv %b line %h want 1 %h", data_rvalid_o, data_rdata_o, LINE_D);
          end
          data_ren_i = 1'b0; rdone = 1;
        end else begin
          n_checks++;
          if (axi_ren_o !== 1'b1 || axi_raddr_o !== 32'h00002000 + rc * 4) begin
            n_errors++; $display("FAIL conc_read_addr beat %0d: ren %b addr %h", rc, axi_ren_o, axi_raddr_o);
          end
          rv = (k % 2 == 0);
        end
      end
      if (!wdone) begin
        if (wc == 8) begin
          n_checks++;
          if (data_bvalid_o !== 1'b1) begin n_errors++; $display("FAIL conc_write_done: bvalid %b want 1", data_bvalid_o); end
          data_wen_i = 1'b0; wdone = 1;
        end else begin
          n_checks++;
          if (axi_wen_o !== 1'b1 || axi_waddr_o !== 32'h00003000 + wc * 4 || axi_wdata_o !== (32'hE0000000 | wc)) begin
            n_errors++; $display("FAIL conc_write_beat %0d: wen %b addr %h data %h", wc, axi_wen_o, axi_waddr_o, axi_wdata_o);
          end
          wv = (k % 3 != 1);
        end
      end
      rdata_valid_i = rv; rdata_i = 32'hD0000000 | rc; wdata_resp_i = wv;
      step();
      if (rv) rc++;
      if (wv) wc++;
      k++;
    end
    rdata_valid_i = 1'b0; wdata_resp_i = 1'b0;
    n_checks++;
    if (!(rdone && wdone)) begin n_errors++; $display("FAIL conc_timeout: rdone %b wdone %b after %0d cycles", rdone, wdone, k); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int seen;
    inst_araddr_i = 32'h00004000; inst_ren_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      rdata_valid_i = 1'b1; rdata_i = 32'h55550000 | i;
      step();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({axi_ren_o, axi_ce_o, inst_rvalid_o, data_rvalid_o} !== 4'b0000 || axi_raddr_o !== 32'd0) begin
      n_errors++; $display("FAIL midreset_ctl: ren %b ce %b irv %b raddr %h want 0", axi_ren_o, axi_ce_o, inst_rvalid_o, axi_raddr_o);
    end
    n_checks++;
    if ({inst_rdata_o, data_rdata_o} !== 512'd0 || axi_sel_o !== 4'b1111) begin
      n_errors++; $display("FAIL midreset_lines: lines nonzero or sel %h", axi_sel_o);
    end
    inst_ren_i = 1'b0; rdata_valid_i = 1'b0;
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      rdata_valid_i = 1'b1;
      step();
      if (inst_rvalid_o || data_rvalid_o || axi_ren_o) seen++;
    end
    rdata_valid_i = 1'b0;
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL midreset_quiet: activity in %0d cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_read();
    test_dcache_write();
    test_simultaneous();
    test_non_preemption();
    test_concurrent();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
